// File: rtl/nt_modulator_channel.sv
// nt_modulator_channel: saturating level register with homeostatic decay, hysteretic quantised level and saturation flags.
// Latency: value updates 1 cycle after a request; level and level_changed lag value by one more cycle.
// Backpressure: none; requests are sampled every cycle and never stall.
module nt_modulator_channel #(
  parameter int N            = 7,
  parameter int DEFAULT_VAL  = 64,
  parameter int SET_VAL      = 64,
  parameter int FAST_STEP    = 3,
  parameter int BASELINE     = 64,
  parameter int DECAY_PERIOD = 16,
  parameter int LEVEL_BITS   = 2,
  parameter int HYST         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  fast,
  input  logic                  setval,
  input  logic                  decay_en,
  output logic [N-1:0]          value,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  level_changed,
  output logic                  sat_hi,
  output logic                  sat_lo
);

  localparam int SB = N - LEVEL_BITS;
  localparam int CW = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [N-1:0]          MAX_V      = {N{1'b1}};
  localparam logic [CW-1:0]         CNT_LAST   = CW'(DECAY_PERIOD - 1);
  localparam logic [LEVEL_BITS-1:0] LEVEL_INIT = LEVEL_BITS'(DEFAULT_VAL >> SB);

  logic [N-1:0]          value_q, value_d;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic                  level_changed_q, level_changed_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [N-1:0]          step_w;
  logic [N:0]            sum_w;
  logic                  active_w;
  logic                  decay_hit_w;
  logic [LEVEL_BITS-1:0] raw_w;
  logic [LEVEL_BITS:0]   level_p1_w;
  logic [N:0]            up_edge_w;
  logic [N-1:0]          dn_edge_w;
  logic                  up_ok_w;
  logic                  dn_ok_w;

  // Value update and idle-cycle decay counter.
  always_comb begin
    step_w      = fast ? N'(FAST_STEP) : N'(1);
    sum_w       = {1'b0, value_q} + {1'b0, step_w};
    active_w    = inc | dec | setval;
    decay_hit_w = decay_en && !active_w && (cnt_q == CNT_LAST);
    value_d     = value_q;
    cnt_d       = cnt_q + CW'(1);
    if (active_w || !decay_en || decay_hit_w) begin
      cnt_d = '0;
    end
    if (setval) begin
      value_d = N'(SET_VAL);
    end else if (inc && !dec) begin
      value_d = sum_w[N] ? MAX_V : sum_w[N-1:0];
    end else if (dec && !inc) begin
      value_d = (value_q < step_w) ? '0 : (value_q - step_w);
    end else if (decay_hit_w) begin
      if (value_q > N'(BASELINE)) begin
        value_d = value_q - N'(1);
      end else if (value_q < N'(BASELINE)) begin
        value_d = value_q + N'(1);
      end
    end
  end

  // Level hysteresis on the registered value. Upward moves need HYST of
  // margin past the boundary directly above the current level, downward moves
  // need more than HYST below the current level's lower edge; either way the
  // level then jumps straight to the raw bucket, however many levels away.
  always_comb begin
    raw_w           = value_q[N-1:SB];
    level_p1_w      = {1'b0, level_q} + (LEVEL_BITS+1)'(1);
    up_edge_w       = {level_p1_w, {SB{1'b0}}};
    dn_edge_w       = {level_q, {SB{1'b0}}};
    up_ok_w         = (raw_w > level_q) &&
                      (({1'b0, value_q} - up_edge_w) >= (N+1)'(HYST));
    dn_ok_w         = (raw_w < level_q) &&
                      ((dn_edge_w - value_q) > N'(HYST));
    level_d         = level_q;
    level_changed_d = 1'b0;
    if (up_ok_w || dn_ok_w) begin
      level_d         = raw_w;
      level_changed_d = 1'b1;
    end
  end

  // State registers; reset drops any pending decay progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q         <= N'(DEFAULT_VAL);
      level_q         <= LEVEL_INIT;
      level_changed_q <= 1'b0;
      cnt_q           <= '0;
    end else begin
      value_q         <= value_d;
      level_q         <= level_d;
      level_changed_q <= level_changed_d;
      cnt_q           <= cnt_d;
    end
  end

  assign value         = value_q;
  assign level         = level_q;
  assign level_changed = level_changed_q;
  assign sat_hi        = (value_q == MAX_V);
  assign sat_lo        = (value_q == '0);

endmodule

// File: tb/tb_nt_modulator_channel.sv
// Directed bench for nt_modulator_channel at default parameters (Q = 32).
module tb_nt_modulator_channel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       fast = 1'b0;
  logic       setval = 1'b0;
  logic       decay_en = 1'b0;
  logic [6:0] value;
  logic [1:0] level;
  logic       level_changed;
  logic       sat_hi;
  logic       sat_lo;

  int n_cmp = 0;
  int n_mis = 0;

  nt_modulator_channel dut (
    .clk           (clk),
    .rst           (rst),
    .inc           (inc),
    .dec           (dec),
    .fast          (fast),
    .setval        (setval),
    .decay_en      (decay_en),
    .value         (value),
    .level         (level),
    .level_changed (level_changed),
    .sat_hi        (sat_hi),
    .sat_lo        (sat_lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic i, input logic d, input logic f, input logic s, input int n);
    inc = i; dec = d; fast = f; setval = s;
    for (int k = 0; k < n; k++) tick();
    inc = 1'b0; dec = 1'b0; fast = 1'b0; setval = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset and release
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_value", 32'(value), 64);
    chk("rst_level", 32'(level), 2);
    chk("rst_lchg", 32'(level_changed), 0);
    chk("rst_sat_hi", 32'(sat_hi), 0);
    chk("rst_sat_lo", 32'(sat_lo), 0);

    cyc(1, 0, 0, 0, 1);
    chk("inc_one", 32'(value), 65);

    // saturate high
    cyc(1, 0, 1, 0, 20);
    chk("fast_to_125", 32'(value), 125);
    cyc(1, 0, 1, 0, 1);
    chk("clamp_127", 32'(value), 127);
    chk("sat_hi_set", 32'(sat_hi), 1);
    cyc(1, 0, 1, 0, 1);
    chk("hold_127", 32'(value), 127);
    chk("sat_hi_hold", 32'(sat_hi), 1);
    chk("sat_lo_at_max", 32'(sat_lo), 0);

    // back to 64, settle level
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 2);
    chk("setval_64", 32'(value), 64);
    chk("settle_level2", 32'(level), 2);

    // downward hysteresis
    cyc(0, 1, 0, 0, 4);
    chk("dec_to_60", 32'(value), 60);
    chk("lvl_hold_60", 32'(level), 2);
    cyc(0, 1, 0, 0, 1);
    chk("dec_to_59", 32'(value), 59);
    chk("lvl_lag_59", 32'(level), 2);
    chk("lchg_lag_59", 32'(level_changed), 0);
    tick();
    chk("lvl_down_1", 32'(level), 1);
    chk("lchg_down", 32'(level_changed), 1);
    tick();
    chk("lchg_once", 32'(level_changed), 0);

    // upward hysteresis
    cyc(1, 0, 0, 0, 4);
    chk("inc_to_63", 32'(value), 63);
    tick();
    chk("lvl_hold_63", 32'(level), 1);
    cyc(1, 0, 0, 0, 5);
    chk("inc_to_68", 32'(value), 68);
    chk("lvl_lag_68", 32'(level), 1);
    tick();
    chk("lvl_up_2", 32'(level), 2);
    chk("lchg_up", 32'(level_changed), 1);

    // decay
    cyc(1, 0, 0, 0, 2);
    chk("inc_to_70", 32'(value), 70);
    decay_en = 1'b1;
    cyc(0, 0, 0, 0, 15);
    chk("decay_wait15", 32'(value), 70);
    tick();
    chk("decay_69", 32'(value), 69);
    cyc(0, 0, 0, 0, 15);
    chk("decay2_wait15", 32'(value), 69);
    tick();
    chk("decay_68", 32'(value), 68);

    // activity restarts the count
    cyc(0, 0, 0, 0, 9);
    chk("pre_inc_68", 32'(value), 68);
    cyc(1, 0, 0, 0, 1);
    chk("restart_inc_69", 32'(value), 69);
    cyc(0, 0, 0, 0, 15);
    chk("restart_wait15", 32'(value), 69);
    tick();
    chk("restart_68", 32'(value), 68);

    // at baseline: no movement
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 40);
    chk("baseline_hold", 32'(value), 64);

    // saturate low, then land on 10
    decay_en = 1'b0;
    cyc(0, 1, 1, 0, 18);
    chk("fast_dec_10", 32'(value), 10);
    cyc(0, 1, 1, 0, 4);
    chk("clamp_0", 32'(value), 0);
    chk("sat_lo_set", 32'(sat_lo), 1);
    cyc(0, 1, 1, 0, 1);
    chk("hold_0", 32'(value), 0);
    cyc(1, 0, 1, 0, 3);
    cyc(1, 0, 0, 0, 1);
    tick();
    chk("back_to_10", 32'(value), 10);
    chk("level_0", 32'(level), 0);

    // setval wins over inc/fast, multi-level jump
    cyc(1, 0, 1, 1, 1);
    chk("setval_prio", 32'(value), 64);
    chk("jump_lag", 32'(level), 0);
    tick();
    chk("jump_level2", 32'(level), 2);
    chk("jump_lchg", 32'(level_changed), 1);
    tick();
    chk("jump_lchg_once", 32'(level_changed), 0);
    cyc(1, 1, 0, 0, 1);
    chk("incdec_hold", 32'(value), 64);
    cyc(1, 1, 1, 0, 1);
    chk("incdec_fast_hold", 32'(value), 64);

    // asynchronous reset mid-decay
    cyc(1, 0, 1, 0, 12);
    chk("up_to_100", 32'(value), 100);
    tick();
    chk("level_3", 32'(level), 3);
    decay_en = 1'b1;
    cyc(0, 0, 0, 0, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_value", 32'(value), 64);
    chk("arst_level", 32'(level), 2);
    chk("arst_lchg", 32'(level_changed), 0);
    tick();
    tick();
    rst = 1'b0;
    cyc(0, 0, 0, 0, 20);
    chk("post_rst_hold", 32'(value), 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
